// File: rtl/ex_muldiv.sv
// Iterative EX-stage multiply/divide unit producing the HI/LO registers.
// One shift-add or restoring shift-subtract step per clock, then a sign-fix writeback cycle.
module ex_muldiv #(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             writeHi,
  input  logic             writeLo,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITERATIONS + 1);
  localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, b_q, hi_q, lo_q;
  logic             is_div_q, neg_q, neg_rem_q, done_q, dbz_q;

  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] mul_hi_d, mul_lo_d, div_hi_d, div_lo_d, div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi_d, step_lo_d;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & operandA[WIDTH-1];
    b_neg     = signed_op & operandB[WIDTH-1];
    a_abs     = a_neg ? -operandA : operandA;
    b_abs     = b_neg ? -operandB : operandB;

    // Multiply: upper half accumulates, lower half holds the multiplier shifting out LSB-first.
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
    mul_hi_d  = mul_sum[WIDTH:1];
    mul_lo_d  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    // Divide: remainder in acc_hi, dividend shifts out of acc_lo while quotient bits shift in.
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_sub   = div_shift[WIDTH-1:0] - b_q;
    div_hi_d  = div_ge ? div_sub : div_shift[WIDTH-1:0];
    div_lo_d  = {acc_lo_q[WIDTH-2:0], div_ge};

    step_hi_d = is_div_q ? div_hi_d : mul_hi_d;
    step_lo_d = is_div_q ? div_lo_d : mul_lo_d;

    prod_raw  = {acc_hi_q, acc_lo_q};
    prod_fix  = neg_q ? -prod_raw : prod_raw;
    quo_fix   = neg_q ? -acc_lo_q : acc_lo_q;
    rem_fix   = neg_rem_q ? -acc_hi_q : acc_hi_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!flush) begin
            if (writeHi) hi_q <= operandA;
            if (writeLo) lo_q <= operandA;
            if (start) begin
              if (op[1] && operandB == '0) begin
                done_q <= 1'b1;
                dbz_q  <= 1'b1;
              end else begin
                is_div_q  <= op[1];
                neg_q     <= a_neg ^ b_neg;
                neg_rem_q <= a_neg;
                acc_hi_q  <= '0;
                acc_lo_q  <= op[1] ? a_abs : b_abs;
                b_q       <= op[1] ? b_abs : a_abs;
                cnt_q     <= '0;
                state_q   <= S_RUN;
              end
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_hi_q <= step_hi_d;
            acc_lo_q <= step_lo_d;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          if (!flush) begin
            done_q <= 1'b1;
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign divByZero = dbz_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
